// File: rtl/uart_rx_frontend.sv
// 8N1 serial receiver: synchronizes rx_in, frames bytes mid-bit, and hands them
// to the core through a one-entry valid/ready buffer with error/overrun pulses.
module uart_rx_frontend #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [1:0]             sync_q;
    logic                   prev_q;
    logic                   rx_s;
    logic                   byte_done;
    logic                   stop_bad;

    logic [DATA_BITS-1:0]   rx_data_q;
    logic                   rx_valid_q;
    logic                   frame_err_q;
    logic                   overrun_q;

    assign rx_s = sync_q[1];

    // Synchronizer and edge history idle high so reset never looks like a start edge.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            sync_q  <= {sync_q[0], rx_in};
            prev_q  <= rx_s;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CW'(1);
        bit_d     = bit_q;
        shift_d   = shift_q;
        byte_done = 1'b0;
        stop_bad  = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (!rx_s && prev_q) state_d = START;
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + BW'(1);
                    if (bit_q == LAST_BIT) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    state_d   = IDLE;
                    byte_done = rx_s;
                    stop_bad  = !rx_s;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!ena) begin
            state_d   = IDLE;
            cnt_d     = '0;
            bit_d     = '0;
            byte_done = 1'b0;
            stop_bad  = 1'b0;
        end
    end

    // A completing byte wins over a simultaneous consume; it is dropped only if the slot stays full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= stop_bad;
            overrun_q   <= 1'b0;
            if (byte_done) begin
                if (rx_valid_q && !rx_ready) begin
                    overrun_q <= 1'b1;
                end else begin
                    rx_data_q  <= shift_q;
                    rx_valid_q <= 1'b1;
                end
            end else if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: doc/uart_rx_frontend.md
Name: uart_rx_frontend

Overview:
Serial receive front end for the tt_um_ARandomNam_example core: converts the raw asynchronous 8N1 serial line on ui_in[0] into bytes delivered to the core over a valid/ready handshake. It sits directly upstream of the core logic inside the top. It also reports framing errors and overruns as single-cycle pulses.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit; must be even and >= 4
DATA_BITS, 8, data bits per frame, LSB first; the port width follows this value

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  design enable from the top; low holds the receiver idle
rx_in  input  1  raw serial line, idle high, asynchronous to clk
rx_data  output  DATA_BITS  received byte; valid while rx_valid=1
rx_valid  output  1  byte available; held until consumed
rx_ready  input  1  consumer accepts rx_data when rx_valid & rx_ready
frame_err  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  one-cycle pulse: completed byte dropped because the buffer was full

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; bit and cycle counters cleared.
  - Both synchronizer flops and the edge-detect flop are set to 1.
  - rx_data=0, rx_valid=0, frame_err=0, overrun=0.
- Synchronizer: two flops on rx_in; rx_s is the 2nd flop. A raw change captured at edge k appears on rx_s after edge k+1.
- Start detect: in IDLE, rx_s=0 with previous rx_s=1 (falling edge) defines cycle 0. Move to START and clear the cycle counter.
- START:
  - At cycle CLKS_PER_BIT/2, sample rx_s.
  - If rx_s=1, treat as a glitch: return to IDLE with no outputs.
  - Otherwise go to DATA and restart the counter.
- DATA:
  - Sample at every CLKS_PER_BIT cycles (mid-bit).
  - Data bit i is sampled at cycle CLKS_PER_BIT/2 + (i+1)*CLKS_PER_BIT and shifted in LSB first.
  - After DATA_BITS samples, go to STOP.
- STOP: sample at cycle CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT, which is 152 at the defaults.
  - Stop bit = 1: offer the byte to the output buffer, then go to IDLE.
  - Stop bit = 0: frame_err=1 for exactly the next cycle and the byte is discarded. Go to IDLE; a new frame needs a fresh 1->0 edge, so a held-low break produces no further frames.
- Output buffer (one entry):
  - Latency: on an accepted stop sample at cycle N, rx_data and rx_valid=1 are visible from cycle N+1.
  - rx_valid stays 1 and rx_data stays stable until a cycle with rx_valid & rx_ready; rx_valid falls the next cycle.
  - If a new byte completes while rx_valid=1 and rx_ready=0: overrun=1 for one cycle, the new byte is dropped, and the old byte is kept.
  - If consume and completion happen in the same cycle: the new byte is loaded, rx_valid stays 1, and overrun stays 0.
  - rx_ready while rx_valid=0 has no effect.
- ena=0:
  - The FSM is forced to IDLE and counters are cleared, aborting any partial frame with no error pulse.
  - The output buffer and handshake keep working, so a pending byte can still be consumed.
  - The synchronizer keeps running.
- Back-to-back frames: IDLE is re-entered at the mid-stop sample, so a start edge arriving half a bit later is detected. There are no dead cycles.
- frame_err and overrun can never assert in the same cycle: a byte with a bad stop bit is never offered to the buffer.

Test Plan:
- Reset then idle line: rx_in=1 for 500 cycles -> rx_valid, frame_err and overrun stay 0; rx_data=0.
- Single frame 0xA5, CLKS_PER_BIT=16, rx_ready=1:
  - rx_data=0xA5 and rx_valid=1 exactly 153 cycles after the rx_s falling edge.
  - rx_valid is high for one cycle.
- Glitch: rx_in low for 5 cycles then high -> returns to IDLE; no rx_valid, no frame_err. A following valid 0x3C is received correctly.
- Framing error: send 0x55 with the stop bit low -> frame_err is a one-cycle pulse at cycle 153; rx_valid stays 0. A break held low for 400 cycles gives only one frame_err.
- Backpressure and overrun, rx_ready=0:
  - Send 0x11 then 0x22 back-to-back -> 0x11 is held and overrun pulses once when 0x22 completes.
  - Raising rx_ready yields 0x11 only.
  - Repeat with rx_ready pulsed in the exact completion cycle of 0x22 -> 0x22 is loaded and overrun stays 0.
- Reset mid-frame and ena: assert rst_n=0 at bit 4 of a frame -> outputs are 0 immediately. Dropping ena at bit 3 -> no byte and no error; the next full frame 0xF0 is received correctly.
